// File: rtl/uart_rx.sv
// Oversampling UART receiver: 16 ticks per bit, 2-flop input synchroniser,
// one-cycle write strobe for good frames and one-cycle pulse on framing error.
module uart_rx #(
  parameter int unsigned DBIT    = 8,
  parameter int unsigned SB_TICK = 16
) (
  input  logic            i_clk,
  input  logic            i_reset_n,
  input  logic            i_rx,
  input  logic            i_s_tick,
  output logic [DBIT-1:0] o_dout,
  output logic            o_rx_done_tick,
  output logic            o_frame_err,
  output logic            o_busy
);

  localparam int unsigned S_W = 6;
  localparam int unsigned N_W = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_DATA  = 3'd2;
  localparam logic [2:0] ST_STOP  = 3'd3;
  localparam logic [2:0] ST_BRK   = 3'd4;

  localparam logic [S_W-1:0] S_MID       = S_W'(7);
  localparam logic [S_W-1:0] S_BIT_LAST  = S_W'(15);
  localparam logic [S_W-1:0] S_STOP_LAST = S_W'(SB_TICK - 1);
  localparam logic [N_W-1:0] N_LAST      = N_W'(DBIT - 1);

  logic [1:0]      rx_sync;
  logic            rx_s;

  logic [2:0]      state, state_next;
  logic [S_W-1:0]  s_cnt, s_cnt_next;
  logic [N_W-1:0]  n_cnt, n_cnt_next;
  logic [DBIT-1:0] sr, sr_next;
  logic            done_next;
  logic            ferr_next;
  logic            busy_next;

  assign rx_s   = rx_sync[1];
  assign o_dout = sr;

  // Line synchroniser; resets to the idle level so reset never looks like a start bit
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      rx_sync <= 2'b11;
    end else begin
      rx_sync <= {rx_sync[0], i_rx};
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state          <= ST_IDLE;
      s_cnt          <= '0;
      n_cnt          <= '0;
      sr             <= '0;
      o_rx_done_tick <= 1'b0;
      o_frame_err    <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      state          <= state_next;
      s_cnt          <= s_cnt_next;
      n_cnt          <= n_cnt_next;
      sr             <= sr_next;
      o_rx_done_tick <= done_next;
      o_frame_err    <= ferr_next;
      o_busy         <= busy_next;
    end
  end

  always_comb begin
    state_next = state;
    s_cnt_next = s_cnt;
    n_cnt_next = n_cnt;
    sr_next    = sr;
    done_next  = 1'b0;
    ferr_next  = 1'b0;

    case (state)
      ST_IDLE: begin
        if (!rx_s) begin
          s_cnt_next = '0;
          state_next = ST_START;
        end
      end

      ST_START: begin
        if (i_s_tick) begin
          if (s_cnt == S_MID) begin
            if (!rx_s) begin
              s_cnt_next = '0;
              n_cnt_next = '0;
              state_next = ST_DATA;
            end else begin
              state_next = ST_IDLE;
            end
          end else begin
            s_cnt_next = s_cnt + S_W'(1);
          end
        end
      end

      // Sample each data bit at its middle, one bit period after the previous sample
      ST_DATA: begin
        if (i_s_tick) begin
          if (s_cnt == S_BIT_LAST) begin
            s_cnt_next = '0;
            sr_next    = {rx_s, sr[DBIT-1:1]};
            if (n_cnt == N_LAST) begin
              state_next = ST_STOP;
            end else begin
              n_cnt_next = n_cnt + N_W'(1);
            end
          end else begin
            s_cnt_next = s_cnt + S_W'(1);
          end
        end
      end

      ST_STOP: begin
        if (i_s_tick) begin
          if (s_cnt == S_STOP_LAST) begin
            if (rx_s) begin
              done_next  = 1'b1;
              state_next = ST_IDLE;
            end else begin
              ferr_next  = 1'b1;
              state_next = ST_BRK;
            end
          end else begin
            s_cnt_next = s_cnt + S_W'(1);
          end
        end
      end

      // Held-low line after a bad stop bit must not be taken as a new start
      ST_BRK: begin
        if (rx_s) begin
          state_next = ST_IDLE;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase

    busy_next = (state_next != ST_IDLE);
  end

endmodule
